mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Brief    : Byte-serial RAM arbiter for instruction fetch and load/store.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        ic_valid,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_instr,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state,    w_state_n;
    logic [1:0]  r_cnt,      w_cnt_n;
    logic        r_tail,     w_tail_n;
    logic [31:0] r_base,     w_base_n;
    logic [1:0]  r_len,      w_len_n;
    logic        r_own_ls,   w_own_ls_n;
    logic [31:0] r_wdata,    w_wdata_n;
    logic [31:0] r_buf,      w_buf_n;
    logic        r_ic_done,  w_ic_done_n;
    logic        r_ls_done,  w_ls_done_n;
    logic [31:0] r_ic_instr, w_ic_instr_n;
    logic [31:0] r_ls_rdata, w_ls_rdata_n;

    logic [1:0]  w_byte_idx;
    logic [31:0] w_merged;
    logic [31:0] w_addr;
    logic        w_io_stall;

    // mem_din carries the byte addressed one cycle earlier; the tail cycle
    // collects the last byte after addressing has finished.
    assign w_byte_idx = r_tail ? r_cnt : (r_cnt - 2'd1);
    assign w_merged   = r_buf | ({24'd0, mem_din} << {w_byte_idx, 3'b000});
    assign w_addr     = r_base + {30'd0, r_cnt};
    assign w_io_stall = io_buffer_full && (r_base >= IO_BASE);

    assign mem_a    = (((r_state == S_READ) && !r_tail) || (r_state == S_WRITE)) ? w_addr : 32'd0;
    assign mem_wr   = rdy && (r_state == S_WRITE) && !w_io_stall;
    assign mem_dout = (r_state == S_WRITE) ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;

    assign ic_done  = r_ic_done;
    assign ls_done  = r_ls_done;
    assign ic_instr = r_ic_instr;
    assign ls_rdata = r_ls_rdata;

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_tail_n     = r_tail;
        w_base_n     = r_base;
        w_len_n      = r_len;
        w_own_ls_n   = r_own_ls;
        w_wdata_n    = r_wdata;
        w_buf_n      = r_buf;
        w_ic_done_n  = 1'b0;
        w_ls_done_n  = 1'b0;
        w_ic_instr_n = r_ic_instr;
        w_ls_rdata_n = r_ls_rdata;
        case (r_state)
            S_IDLE: begin
                // Requesters drop valid the cycle their done is high.
                if (!r_ic_done && !r_ls_done) begin
                    if (ls_valid) begin
                        w_state_n  = ls_wr ? S_WRITE : S_READ;
                        w_base_n   = ls_addr;
                        w_len_n    = ls_len;
                        w_own_ls_n = 1'b1;
                        w_wdata_n  = ls_wdata;
                        w_cnt_n    = 2'd0;
                        w_tail_n   = 1'b0;
                        w_buf_n    = 32'd0;
                    end else if (ic_valid && !clear) begin
                        w_state_n  = S_READ;
                        w_base_n   = ic_addr;
                        w_len_n    = 2'd3;
                        w_own_ls_n = 1'b0;
                        w_cnt_n    = 2'd0;
                        w_tail_n   = 1'b0;
                        w_buf_n    = 32'd0;
                    end
                end
            end
            S_READ: begin
                if (clear) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = 2'd0;
                    w_tail_n  = 1'b0;
                end else if (r_tail) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = 2'd0;
                    w_tail_n  = 1'b0;
                    if (r_own_ls) begin
                        w_ls_rdata_n = w_merged;
                        w_ls_done_n  = 1'b1;
                    end else begin
                        w_ic_instr_n = w_merged;
                        w_ic_done_n  = 1'b1;
                    end
                end else begin
                    if (r_cnt != 2'd0) begin
                        w_buf_n = w_merged;
                    end
                    if (r_cnt == r_len) begin
                        w_tail_n = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                // Stores ignore clear: they are already committed.
                if (!w_io_stall) begin
                    if (r_cnt == r_len) begin
                        w_state_n   = S_IDLE;
                        w_cnt_n     = 2'd0;
                        w_ls_done_n = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_tail     <= 1'b0;
            r_base     <= 32'd0;
            r_len      <= 2'd0;
            r_own_ls   <= 1'b0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_ic_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_ic_instr <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (rdy) begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_tail     <= w_tail_n;
            r_base     <= w_base_n;
            r_len      <= w_len_n;
            r_own_ls   <= w_own_ls_n;
            r_wdata    <= w_wdata_n;
            r_buf      <= w_buf_n;
            r_ic_done  <= w_ic_done_n;
            r_ls_done  <= w_ls_done_n;
            r_ic_instr <= w_ic_instr_n;
            r_ls_rdata <= w_ls_rdata_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Brief    : Scoreboard bench for mem_ctrl with a byte-array memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        ic_valid;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_instr;
    logic        ls_valid, ls_wr;
    logic [1:0]  ls_len;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_instr(ic_instr),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'd2654435761;
        case (i)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h300: return 8'h80;
            default: return v[23:16];
        endcase
    endfunction

    // Bench-side RAM the DUT talks to; the I/O region is not backed by it.
    logic [7:0] ram [0:4095];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (mem_wr && (mem_a < IO_BASE)) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    // Reference model: architectural memory image and expected responses.
    logic [7:0] ref_mem [0:4095];
    typedef struct { bit is_ic; bit is_store; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } iow_t;
    exp_t sb[$];
    iow_t io_exp[$];

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] len);
        logic [31:0] r, a;
        r = 32'd0;
        for (int k = 0; k <= int'(len); k++) begin
            a = addr + 32'(k);
            r = r | (32'(ref_mem[a[11:0]]) << (8 * k));
        end
        return r;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wd);
        logic [31:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            a = addr + 32'(k);
            if (addr >= IO_BASE) io_exp.push_back('{a: a, d: wd[8*k +: 8]});
            else ref_mem[a[11:0]] = wd[8*k +: 8];
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        exp_t e;
        iow_t w;
        if (!rst) begin
            if (ic_done && ls_done) check("both_done", 32'(ic_done & ls_done), 32'd0);
            if (ic_done || ls_done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'({ic_done, ls_done}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", 32'(ic_done), 32'(e.is_ic));
                    if (!e.is_store) begin
                        if (e.is_ic) check("ic_instr", ic_instr, e.data);
                        else         check("ls_rdata", ls_rdata, e.data);
                    end
                end
            end
            if (mem_wr && (mem_a >= IO_BASE)) begin
                check("io_full_respect", 32'(io_buffer_full), 32'd0);
                if (io_exp.size() == 0) begin
                    check("io_unexpected", mem_a, 32'd0);
                end else begin
                    w = io_exp.pop_front();
                    check("io_addr", mem_a, w.a);
                    check("io_data", 32'(mem_dout), 32'(w.d));
                end
            end
        end
    end

    logic [31:0] rec_a  [0:15];
    logic        rec_wr [0:15];
    logic [7:0]  rec_d  [0:15];

    task automatic run_req(input bit is_ls, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit rec, output int lat);
        lat = -1;
        @(posedge clk); #1;
        if (is_ls) begin
            ls_valid = 1'b1; ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wdata;
        end else begin
            ic_valid = 1'b1; ic_addr = addr;
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #2;
            if (rec && k < 16) begin
                rec_a[k] = mem_a; rec_wr[k] = mem_wr; rec_d[k] = mem_dout;
            end
            if ((is_ls && ls_done) || (!is_ls && ic_done)) begin
                lat = k;
                break;
            end
        end
        if (is_ls) ls_valid = 1'b0;
        else       ic_valid = 1'b0;
        if (lat < 0) check(is_ls ? "ls_timeout" : "ic_timeout", 32'(is_ls ? ls_done : ic_done), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int lat;
        sb.push_back('{is_ic: 1'b1, is_store: 1'b0, data: model_read(addr, 2'd3)});
        run_req(1'b0, 1'b0, 2'd3, addr, 32'd0, 1'b0, lat);
        if (lat >= 0) check("fetch_latency", 32'(lat), 32'd6);
    endtask

    task automatic do_load(input logic [1:0] len, input logic [31:0] addr);
        int lat;
        sb.push_back('{is_ic: 1'b0, is_store: 1'b0, data: model_read(addr, len)});
        run_req(1'b1, 1'b0, len, addr, 32'd0, 1'b0, lat);
        if (lat >= 0) check("load_latency", 32'(lat), 32'(len) + 32'd3);
    endtask

    task automatic do_store(input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wd,
                            input bit rec);
        int lat;
        model_store(addr, len, wd);
        sb.push_back('{is_ic: 1'b0, is_store: 1'b1, data: 32'd0});
        run_req(1'b1, 1'b1, len, addr, wd, rec, lat);
        if (lat >= 0) check("store_latency", 32'(lat), 32'(len) + 32'd2);
    endtask

    task automatic do_io_store(input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wd);
        int lat;
        bit io_run;
        model_store(addr, len, wd);
        sb.push_back('{is_ic: 1'b0, is_store: 1'b1, data: 32'd0});
        io_run = 1'b1;
        fork
            begin
                run_req(1'b1, 1'b1, len, addr, wd, 1'b0, lat);
                io_run = 1'b0;
            end
            begin
                while (io_run) begin
                    @(posedge clk); #1;
                    if (io_run) io_buffer_full = ($urandom_range(0, 2) == 0);
                end
                io_buffer_full = 1'b0;
            end
        join
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ic_done"},  32'(ic_done),  32'd0);
        check({tag, "_ls_done"},  32'(ls_done),  32'd0);
        check({tag, "_ic_instr"}, ic_instr,      32'd0);
        check({tag, "_ls_rdata"}, ls_rdata,      32'd0);
        check({tag, "_mem_wr"},   32'(mem_wr),   32'd0);
        check({tag, "_mem_a"},    mem_a,         32'd0);
        check({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_a, lat_b, sel;
        bit seen;
        logic [1:0]  len;
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        ic_valid = 1'b0; ic_addr = 32'd0;
        ls_valid = 1'b0; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

        repeat (3) @(posedge clk);
        #3;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reference fetch with address trace.
        sb.push_back('{is_ic: 1'b1, is_store: 1'b0, data: 32'h0010_0513});
        run_req(1'b0, 1'b0, 2'd3, 32'h100, 32'd0, 1'b1, lat_a);
        check("fetch_lat_ref", 32'(lat_a), 32'd6);
        for (int k = 1; k <= 4; k++) begin
            check("fetch_addr", rec_a[k], 32'h100 + 32'(k - 1));
            check("fetch_nowr", 32'(rec_wr[k]), 32'd0);
        end

        // Halfword store trace.
        do_store(2'd1, 32'h200, 32'hAABB_CCDD, 1'b1);
        check("st_wr1", 32'(rec_wr[1]), 32'd1);
        check("st_a1", rec_a[1], 32'h200);
        check("st_d1", 32'(rec_d[1]), 32'hDD);
        check("st_wr2", 32'(rec_wr[2]), 32'd1);
        check("st_a2", rec_a[2], 32'h201);
        check("st_d2", 32'(rec_d[2]), 32'hCC);

        // Simultaneous requests: load wins, fetch follows.
        sb.push_back('{is_ic: 1'b0, is_store: 1'b0, data: 32'h0000_0080});
        sb.push_back('{is_ic: 1'b1, is_store: 1'b0, data: model_read(32'h400, 2'd3)});
        fork
            run_req(1'b1, 1'b0, 2'd0, 32'h300, 32'd0, 1'b0, lat_a);
            run_req(1'b0, 1'b0, 2'd3, 32'h400, 32'd0, 1'b0, lat_b);
        join
        check("prio_ls_lat", 32'(lat_a), 32'd3);
        check("prio_ic_lat", 32'(lat_b), 32'd10);

        // I/O store held off by a full buffer for three cycles.
        model_store(IO_BASE, 2'd0, 32'h41);
        sb.push_back('{is_ic: 1'b0, is_store: 1'b1, data: 32'd0});
        fork
            run_req(1'b1, 1'b1, 2'd0, IO_BASE, 32'h41, 1'b1, lat_a);
            begin
                @(posedge clk); @(posedge clk); #1 io_buffer_full = 1'b1;
                repeat (3) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
        join
        check("io_lat", 32'(lat_a), 32'd5);
        for (int k = 1; k <= 3; k++) check("io_stall_nowr", 32'(rec_wr[k]), 32'd0);
        check("io_wr", 32'(rec_wr[4]), 32'd1);
        check("io_d", 32'(rec_d[4]), 32'h41);

        // Global stall during a store.
        model_store(32'h220, 2'd1, 32'h0000_5A6B);
        sb.push_back('{is_ic: 1'b0, is_store: 1'b1, data: 32'd0});
        fork
            run_req(1'b1, 1'b1, 2'd1, 32'h220, 32'h0000_5A6B, 1'b1, lat_a);
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (2) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        check("rdy_lat", 32'(lat_a), 32'd5);
        check("rdy_nowr", 32'(rec_wr[2]), 32'd0);
        check("rdy_hold_a", rec_a[2], 32'h221);
        check("rdy_resume_wr", 32'(rec_wr[4]), 32'd1);
        check("rdy_resume_a", rec_a[4], 32'h221);
        do_load(2'd1, 32'h220);

        // Flush during a fetch.
        @(posedge clk); #1 ic_valid = 1'b1; ic_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; ic_valid = 1'b0;
        #2 check("clear_idle_a", mem_a, 32'd0);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #3; seen = seen | ic_done; end
        check("clear_no_done", 32'(seen), 32'd0);

        // Flush during a store does not abort it.
        model_store(32'h240, 2'd3, 32'h1122_3344);
        sb.push_back('{is_ic: 1'b0, is_store: 1'b1, data: 32'd0});
        fork
            run_req(1'b1, 1'b1, 2'd3, 32'h240, 32'h1122_3344, 1'b0, lat_a);
            begin
                repeat (4) @(posedge clk);
                #1 clear = 1'b1;
                @(posedge clk); #1 clear = 1'b0;
            end
        join
        check("clear_store_lat", 32'(lat_a), 32'd5);
        do_load(2'd3, 32'h240);

        // Flush together with a fetch request in idle: not accepted.
        @(posedge clk); #1 ic_valid = 1'b1; ic_addr = 32'h500; clear = 1'b1;
        @(posedge clk); #1 ic_valid = 1'b0; clear = 1'b0;
        #2 check("clear_noaccept_a", mem_a, 32'd0);
        repeat (3) @(posedge clk);

        // Reset in the middle of a word load.
        @(posedge clk); #1 ls_valid = 1'b1; ls_wr = 1'b0; ls_len = 2'd3; ls_addr = 32'h100;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; ls_valid = 1'b0;
        #2 check_idle_outputs("midrst");
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #3; seen = seen | ls_done; end
        check("midrst_no_done", 32'(seen), 32'd0);
        do_fetch(32'h100);

        // Wrap-around load.
        do_load(2'd3, 32'hFFFF_FFFE);

        // Randomised traffic.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       len = 2'd0;
                1:       len = 2'd1;
                default: len = 2'd3;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'($urandom_range(0, 1023));
            if (sel < 3)      do_fetch(a);
            else if (sel < 6) do_load(len, a);
            else if (sel < 9) do_store(len, 32'($urandom_range(0, 1023)), $urandom, 1'b0);
            else              do_io_store(len, IO_BASE + 32'($urandom_range(0, 255)), $urandom);
        end

        repeat (5) @(posedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("io_drained", 32'(io_exp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
